fb_scheduler: RTL and testbench

FB_SCHEDULER -- requirements
Module: fb_scheduler

---
 rtl/fb_scheduler.sv | 214 +++++++++++++++++++++
 tb/tb_fb_scheduler.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_scheduler.sv
// Triple-buffered frame store scheduler: arbitrates display read bursts against
// capture write bursts on one memory port and rotates banks at frame boundaries.
module fb_scheduler #(
    parameter int BURST_LEN     = 8,
    parameter int FRAME_WORDS   = 414720,
    parameter int OFFS_W        = 19,
    parameter int RD_STREAK_MAX = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_frame_start,
    input  logic              rd_need,
    input  logic              wr_ready,
    input  logic              wr_frame_done,
    input  logic              mem_gnt,
    input  logic              mem_done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [OFFS_W+1:0] mem_addr,
    output logic              rd_active,
    output logic              wr_active,
    output logic [1:0]        rd_bank,
    output logic [1:0]        wr_bank,
    output logic              rd_fetch_done,
    output logic              wr_full,
    output logic              frame_drop,
    output logic              underrun
);

    localparam int OW1      = OFFS_W + 1;
    localparam int STREAK_W = (RD_STREAK_MAX < 1) ? 1 : $clog2(RD_STREAK_MAX + 1);

    localparam logic [OFFS_W:0]   FRAME_END  = OW1'(FRAME_WORDS);
    localparam logic [OFFS_W:0]   BURST_STEP = OW1'(BURST_LEN);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(RD_STREAK_MAX);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_BURST = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          rd_bank_q, rd_bank_d;
    logic [1:0]          wr_bank_q, wr_bank_d;
    logic [1:0]          rdy_bank_q, rdy_bank_d;
    logic                rdy_valid_q, rdy_valid_d;
    logic [OFFS_W-1:0]   rd_offs_q, rd_offs_d;
    logic [OFFS_W-1:0]   wr_offs_q, wr_offs_d;
    logic [STREAK_W-1:0] rd_streak_q, rd_streak_d;
    logic                rd_start_pend_q, rd_start_pend_d;
    logic                wr_done_pend_q, wr_done_pend_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [OFFS_W+1:0]   mem_addr_q, mem_addr_d;
    logic                rd_active_q, rd_active_d;
    logic                wr_active_q, wr_active_d;
    logic                frame_drop_q, frame_drop_d;
    logic                underrun_q, underrun_d;

    logic              rd_elig, wr_elig, wr_wins;
    logic              rd_offs_short, wr_offs_short;
    logic [OFFS_W:0]   rd_offs_sum, wr_offs_sum;
    logic [OFFS_W-1:0] rd_offs_step, wr_offs_step;

    assign rd_offs_short = ({1'b0, rd_offs_q} < FRAME_END);
    assign wr_offs_short = ({1'b0, wr_offs_q} < FRAME_END);
    assign rd_elig       = rd_need && rd_offs_short;
    assign wr_elig       = wr_ready && wr_offs_short;
    assign wr_wins       = wr_elig && ((rd_streak_q == STREAK_MAX) || !rd_elig);

    // Offsets advance one burst at a time but clamp at the frame end.
    assign rd_offs_sum  = {1'b0, rd_offs_q} + BURST_STEP;
    assign wr_offs_sum  = {1'b0, wr_offs_q} + BURST_STEP;
    assign rd_offs_step = (rd_offs_sum > FRAME_END) ? FRAME_END[OFFS_W-1:0] : rd_offs_sum[OFFS_W-1:0];
    assign wr_offs_step = (wr_offs_sum > FRAME_END) ? FRAME_END[OFFS_W-1:0] : wr_offs_sum[OFFS_W-1:0];

    always_comb begin
        state_d         = state_q;
        rd_bank_d       = rd_bank_q;
        wr_bank_d       = wr_bank_q;
        rdy_bank_d      = rdy_bank_q;
        rdy_valid_d     = rdy_valid_q;
        rd_offs_d       = rd_offs_q;
        wr_offs_d       = wr_offs_q;
        rd_streak_d     = rd_streak_q;
        rd_start_pend_d = rd_start_pend_q | rd_frame_start;
        wr_done_pend_d  = wr_done_pend_q | wr_frame_done;
        mem_req_d       = mem_req_q;
        mem_we_d        = mem_we_q;
        mem_addr_d      = mem_addr_q;
        rd_active_d     = rd_active_q;
        wr_active_d     = wr_active_q;
        frame_drop_d    = 1'b0;
        underrun_d      = underrun_q;

        case (state_q)
            S_IDLE: begin
                if (rd_start_pend_q || wr_done_pend_q) begin
                    // Pulses landing in this very cycle stay pending for the next one.
                    rd_start_pend_d = rd_frame_start;
                    wr_done_pend_d  = wr_frame_done;
                    if (wr_done_pend_q) begin
                        wr_bank_d    = rdy_bank_q;
                        rdy_bank_d   = wr_bank_q;
                        frame_drop_d = rdy_valid_q;
                        rdy_valid_d  = 1'b1;
                        wr_offs_d    = '0;
                    end
                    if (rd_start_pend_q) begin
                        if (rdy_valid_d) begin
                            rd_bank_d  = rdy_bank_d;
                            rdy_bank_d = rd_bank_q;
                        end
                        rdy_valid_d = 1'b0;
                        underrun_d  = underrun_q | rd_offs_short;
                        rd_offs_d   = '0;
                    end
                end else if (wr_wins) begin
                    state_d    = S_REQ;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b1;
                    mem_addr_d = {wr_bank_q, wr_offs_q};
                end else if (rd_elig) begin
                    state_d    = S_REQ;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = {rd_bank_q, rd_offs_q};
                end
            end
            S_REQ: begin
                if (mem_gnt) begin
                    state_d     = S_BURST;
                    mem_req_d   = 1'b0;
                    rd_active_d = !mem_we_q;
                    wr_active_d = mem_we_q;
                    if (mem_we_q) begin
                        rd_streak_d = '0;
                    end else if (wr_elig && (rd_streak_q != STREAK_MAX)) begin
                        rd_streak_d = rd_streak_q + 1'b1;
                    end
                end
            end
            S_BURST: begin
                if (mem_done) begin
                    state_d     = S_IDLE;
                    rd_active_d = 1'b0;
                    wr_active_d = 1'b0;
                    if (mem_we_q) begin
                        wr_offs_d = wr_offs_step;
                    end else begin
                        rd_offs_d = rd_offs_step;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= S_IDLE;
            rd_bank_q       <= 2'd0;
            wr_bank_q       <= 2'd1;
            rdy_bank_q      <= 2'd2;
            rdy_valid_q     <= 1'b0;
            rd_offs_q       <= '0;
            wr_offs_q       <= '0;
            rd_streak_q     <= '0;
            rd_start_pend_q <= 1'b0;
            wr_done_pend_q  <= 1'b0;
            mem_req_q       <= 1'b0;
            mem_we_q        <= 1'b0;
            mem_addr_q      <= '0;
            rd_active_q     <= 1'b0;
            wr_active_q     <= 1'b0;
            frame_drop_q    <= 1'b0;
            underrun_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            rd_bank_q       <= rd_bank_d;
            wr_bank_q       <= wr_bank_d;
            rdy_bank_q      <= rdy_bank_d;
            rdy_valid_q     <= rdy_valid_d;
            rd_offs_q       <= rd_offs_d;
            wr_offs_q       <= wr_offs_d;
            rd_streak_q     <= rd_streak_d;
            rd_start_pend_q <= rd_start_pend_d;
            wr_done_pend_q  <= wr_done_pend_d;
            mem_req_q       <= mem_req_d;
            mem_we_q        <= mem_we_d;
            mem_addr_q      <= mem_addr_d;
            rd_active_q     <= rd_active_d;
            wr_active_q     <= wr_active_d;
            frame_drop_q    <= frame_drop_d;
            underrun_q      <= underrun_d;
        end
    end

    assign mem_req       = mem_req_q;
    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign rd_active     = rd_active_q;
    assign wr_active     = wr_active_q;
    assign rd_bank       = rd_bank_q;
    assign wr_bank       = wr_bank_q;
    assign rd_fetch_done = ({1'b0, rd_offs_q} == FRAME_END);
    assign wr_full       = ({1'b0, wr_offs_q} == FRAME_END);
    assign frame_drop    = frame_drop_q;
    assign underrun      = underrun_q;

endmodule

// File: tb/tb_fb_scheduler.sv
// Bench for fb_scheduler: directed frame/bank scenarios followed by random traffic,
// all checked against a bank-rotation and offset model kept here.
module tb_fb_scheduler;

    localparam int BL = 8;
    localparam int FW = 64;
    localparam int OW = 19;
    localparam int SM = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic rd_frame_start = 1'b0, rd_need = 1'b0, wr_ready = 1'b0, wr_frame_done = 1'b0;
    logic mem_gnt = 1'b0, mem_done = 1'b0;
    logic mem_req, mem_we, rd_active, wr_active, rd_fetch_done, wr_full, frame_drop, underrun;
    logic [OW+1:0] mem_addr;
    logic [1:0] rd_bank, wr_bank;

    int tests = 0;
    int fails = 0;

    // Reference model state
    int m_rd, m_wr, m_rdy;
    bit m_valid, m_underrun, m_rs_pend, m_wd_pend;
    int m_rd_offs, m_wr_offs, m_streak;

    fb_scheduler #(.BURST_LEN(BL), .FRAME_WORDS(FW), .OFFS_W(OW), .RD_STREAK_MAX(SM)) dut (
        .clk(clk), .reset(reset),
        .rd_frame_start(rd_frame_start), .rd_need(rd_need),
        .wr_ready(wr_ready), .wr_frame_done(wr_frame_done),
        .mem_gnt(mem_gnt), .mem_done(mem_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .rd_active(rd_active), .wr_active(wr_active),
        .rd_bank(rd_bank), .wr_bank(wr_bank),
        .rd_fetch_done(rd_fetch_done), .wr_full(wr_full),
        .frame_drop(frame_drop), .underrun(underrun)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset;
        m_rd = 0; m_wr = 1; m_rdy = 2; m_valid = 0;
        m_rd_offs = 0; m_wr_offs = 0; m_streak = 0;
        m_underrun = 0; m_rs_pend = 0; m_wd_pend = 0;
    endtask

    // Write rule first, then read rule.
    task automatic model_apply(output bit drop);
        int t;
        drop = 0;
        if (m_wd_pend) begin
            t = m_wr; m_wr = m_rdy; m_rdy = t;
            drop = m_valid;
            m_valid = 1;
            m_wr_offs = 0;
        end
        if (m_rs_pend) begin
            if (m_valid) begin
                t = m_rd; m_rd = m_rdy; m_rdy = t;
            end
            m_valid = 0;
            if (m_rd_offs < FW) m_underrun = 1;
            m_rd_offs = 0;
        end
        m_rs_pend = 0;
        m_wd_pend = 0;
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_rd_bank"}, rd_bank, m_rd);
        chk({tag, "_wr_bank"}, wr_bank, m_wr);
        chk({tag, "_fetch_done"}, rd_fetch_done, m_rd_offs == FW);
        chk({tag, "_wr_full"}, wr_full, m_wr_offs == FW);
        chk({tag, "_underrun"}, underrun, m_underrun);
        chk({tag, "_perm"}, (rd_bank != wr_bank) && (rd_bank < 3) && (wr_bank < 3), 1);
    endtask

    task automatic frames(input bit rs, input bit wd);
        bit drop;
        if (!rs && !wd) return;
        rd_frame_start = rs; wr_frame_done = wd;
        tick;
        rd_frame_start = 0; wr_frame_done = 0;
        m_rs_pend = rs; m_wd_pend = wd;
        chk("frame_drop_pre", frame_drop, 0);
        tick;
        model_apply(drop);
        chk("frame_drop", frame_drop, drop);
        check_state("frames");
    endtask

    // One request/grant/done handshake; optional frame pulses while in BURST.
    task automatic burst(input bit need, input bit wrdy, input int gnt_wait,
                         input bit rs_b, input bit wd_b, input int n_pulse,
                         output bit was_w, output logic [31:0] addr_o);
        bit re, we_e, sel_w, drop;
        logic [31:0] ea;
        was_w = 0;
        addr_o = '1;
        rd_need = need; wr_ready = wrdy;
        re   = need && (m_rd_offs < FW);
        we_e = wrdy && (m_wr_offs < FW);
        if (!re && !we_e) begin
            tick; tick;
            chk("no_req", mem_req, 0);
            rd_need = 0; wr_ready = 0;
            return;
        end
        sel_w = we_e && ((m_streak == SM) || !re);
        ea = sel_w ? ((m_wr << OW) | m_wr_offs) : ((m_rd << OW) | m_rd_offs);
        was_w = sel_w;
        addr_o = ea;
        tick;
        chk("mem_req", mem_req, 1);
        chk("mem_we", mem_we, sel_w);
        chk("mem_addr", mem_addr, ea);
        if (mem_req !== 1'b1) begin
            rd_need = 0; wr_ready = 0;
            return;
        end
        for (int i = 0; i < gnt_wait; i++) begin
            tick;
            chk("req_hold", mem_req, 1);
        end
        mem_gnt = 1;
        tick;
        mem_gnt = 0;
        if (sel_w) m_streak = 0;
        else if (we_e && m_streak < SM) m_streak++;
        chk("rd_active", rd_active, !sel_w);
        chk("wr_active", wr_active, sel_w);
        chk("req_clear", mem_req, 0);
        chk("addr_hold", mem_addr, ea);
        rd_need = 0; wr_ready = 0;
        for (int i = 0; i < n_pulse; i++) begin
            rd_frame_start = rs_b; wr_frame_done = wd_b;
            tick;
            rd_frame_start = 0; wr_frame_done = 0;
            tick;
        end
        if (n_pulse > 0) begin
            m_rs_pend = rs_b; m_wd_pend = wd_b;
            chk("burst_bank_hold", rd_bank, m_rd);
        end
        mem_done = 1;
        tick;
        mem_done = 0;
        chk("rd_active_end", rd_active, 0);
        chk("wr_active_end", wr_active, 0);
        if (sel_w) m_wr_offs = (m_wr_offs + BL > FW) ? FW : m_wr_offs + BL;
        else       m_rd_offs = (m_rd_offs + BL > FW) ? FW : m_rd_offs + BL;
        if (m_rs_pend || m_wd_pend) begin
            tick;
            model_apply(drop);
            chk("burst_frame_drop", frame_drop, drop);
            check_state("after_burst");
        end
    endtask

    initial begin
        bit w;
        logic [31:0] a;
        logic [5:0] order;
        int old_wr, old_rdy;

        // Asynchronous reset: outputs settle before any clock edge.
        model_reset();
        #2 reset = 1;
        #1;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_rd_bank", rd_bank, 0);
        chk("rst_wr_bank", wr_bank, 1);
        chk("rst_underrun", underrun, 0);
        chk("rst_frame_drop", frame_drop, 0);
        tick; tick;
        reset = 0;
        tick;

        // First read burst at bank 0 offset 0, then offset 8.
        burst(1, 0, 1, 0, 0, 0, w, a);
        chk("s1_first_addr", a, 32'h0);
        burst(1, 0, 0, 0, 0, 0, w, a);
        chk("s1_second_addr", a, 32'h8);

        // Read/write interleave under contention.
        order = '0;
        for (int i = 0; i < 6; i++) begin
            burst(1, 1, 0, 0, 0, 0, w, a);
            order[i] = w;
            if (i == 2) chk("s2_wr_addr0", a, 32'h80000);
            if (i == 5) chk("s2_wr_addr1", a, 32'h80008);
        end
        chk("s2_order", order, 6'b100100);

        // Completed frame shown on next display frame; early start underruns.
        frames(0, 1);
        frames(1, 0);
        chk("s3_rd_bank", rd_bank, 1);
        chk("s3_wr_bank", wr_bank, 2);
        chk("s3_underrun", underrun, 1);

        // Two completed frames without a display start drop one.
        frames(0, 1);
        frames(0, 1);

        // Both frame events during a burst, applied once back in IDLE.
        old_wr = m_wr; old_rdy = m_rdy;
        burst(1, 0, 0, 1, 1, 1, w, a);
        chk("s5_rd_bank", rd_bank, old_wr);
        chk("s5_wr_bank", wr_bank, old_rdy);

        // Repeated pulses during one burst merge into a single application.
        burst(1, 0, 0, 0, 1, 2, w, a);

        // Fill the capture bank; further write requests are suppressed.
        for (int i = 0; i < FW / BL; i++) burst(0, 1, 0, 0, 0, 0, w, a);
        chk("s6_wr_full", wr_full, 1);
        burst(0, 1, 0, 0, 0, 0, w, a);
        frames(0, 1);
        chk("s6_wr_full_clear", wr_full, 0);

        // Reset in the middle of a burst abandons it.
        rd_need = 1;
        tick;
        mem_gnt = 1;
        tick;
        mem_gnt = 0; rd_need = 0;
        chk("mid_rd_active", rd_active, 1);
        #2 reset = 1;
        #1;
        chk("mid_rst_rd_active", rd_active, 0);
        chk("mid_rst_rd_bank", rd_bank, 0);
        chk("mid_rst_wr_bank", wr_bank, 1);
        chk("mid_rst_underrun", underrun, 0);
        tick;
        reset = 0;
        model_reset();
        tick;
        burst(1, 0, 0, 0, 0, 0, w, a);
        chk("mid_rst_restart_addr", a, 32'h0);

        // Random traffic against the model.
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 9) < 7) begin
                bit pr, pw;
                int np;
                pr = ($urandom_range(0, 5) == 0);
                pw = ($urandom_range(0, 5) == 0);
                np = (pr || pw) ? $urandom_range(1, 2) : 0;
                burst($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 2),
                      pr, pw, np, w, a);
            end else begin
                frames($urandom_range(0, 1), $urandom_range(0, 1));
            end
        end
        check_state("final");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
